serial_logic16: RTL
===================

// Module: serial_logic16
// PURPOSE
//   Bit-serial counterpart of the parallel 16-bit gate arrays: computes AND/OR/XOR/NAND
//   of two 16-bit operands STEP bits per clock, behind valid/ready handshakes.
//   Area-lean logic unit for the low-cost datapath variant; sits between operand
//   registers and the writeback mux.
// PARAMETERS
//   WIDTH  16  operand/result width in bits
//   STEP   1   bits processed per cycle; must divide WIDTH (1, 2, 4, 8, 16 legal)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operands/op presented
//   in_ready   out  1      unit can accept (high only in IDLE)
//   op         in   2      00 AND, 01 OR, 10 XOR, 11 NAND; sampled on accept
//   a16        in   WIDTH  operand A; sampled on accept
//   b16        in   WIDTH  operand B; sampled on accept
//   out_valid  out  1      y16 holds a completed result
//   out_ready  in   1      consumer takes result
//   y16        out  WIDTH  result
//   busy       out  1      high in RUN or DONE
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, busy=0,
//     y16=0, counter=0, operand shift regs=0. Reset mid-RUN/DONE aborts; result discarded.
//   - FSM IDLE -> RUN -> DONE -> IDLE. N = WIDTH/STEP.
//   - IDLE: in_ready=1. Edge with in_valid=1: latch a16, b16, op; cnt=0; -> RUN.
//     in_valid=0: stay. Inputs ignored outside the accepting edge.
//   - RUN: each edge applies op to STEP LSBs of A/B regs, shifts result in from MSB
//     side of result reg (right shift by STEP); A/B shift right by STEP; cnt+=1.
//     On edge where cnt==N-1: -> DONE. Result bit i = op(a[i], b[i]) exactly.
//   - DONE: out_valid=1, y16 = full result, stable until handshake. Edge with
//     out_ready=1: -> IDLE, out_valid=0. out_ready while not DONE is ignored.
//   - Latency: out_valid rises N edges after accepting edge (16 at defaults).
//     No overlap: next accept earliest one edge after result handshake; throughput
//     1 op per N+2 cycles with zero stall.
//   - y16 keeps last result after handshake until the next completion overwrites it;
//     consumers qualify with out_valid. During RUN y16 holds the previous result.
//   - cnt width = clog2(N) (min 1); no wrap beyond N-1. STEP=WIDTH gives N=1: result
//     computed on the first RUN edge.
//   - in_valid and out_ready both high in DONE: only result handshake occurs; in_ready=0.
// STRUCTURE
//   - Package iceberg_logic_pkg: op codes OP_AND/OP_OR/OP_XOR/OP_NAND (2-bit localparams),
//     state encoding S_IDLE/S_RUN/S_DONE.
//   - Sub-module logic_slice #(STEP): combinational op over STEP bit pairs; one instance.
//   - Top: FSM, counter, A/B/result shift registers, handshake logic.
// TESTING
//   1. Reset, then AND a16=16'hF0F0 b16=16'hFF00 -> out_valid after 16 edges, y16=16'hF000.
//   2. OR/XOR/NAND on a16=16'h1234 b16=16'h00FF -> 16'h12FF / 16'h12CB / 16'hFFCB.
//   3. Hold out_ready=0 for 10 cycles in DONE -> y16, out_valid stable; in_ready=0.
//   4. Assert rst at RUN cycle 7 -> next cycle state IDLE, out_valid=0, y16=0, in_ready=1.
//   5. Back-to-back ops with in_valid/out_ready tied high -> one result every 18 cycles.
//   6. STEP=4 and STEP=16 builds, XOR 16'hAAAA^16'h5555 -> 16'hFFFF after 4 / 1 edge(s).

Source files
------------

// File: rtl/iceberg_logic_pkg.sv
// Shared op codes, FSM encoding and sizing helper for the bit-serial logic unit.
package iceberg_logic_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A single-step build still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/logic_slice.sv
// Combinational AND/OR/XOR/NAND over STEP bit pairs.
module logic_slice
  import iceberg_logic_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic [1:0]      op,
  input  logic [STEP-1:0] a,
  input  logic [STEP-1:0] b,
  output logic [STEP-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = ~(a & b);
    endcase
  end

endmodule

// File: rtl/serial_logic16.sv
// Bit-serial logic unit: latches two operands, processes STEP bits per clock,
// and presents the result behind a valid/ready pair.
//   state  | meaning
//   S_IDLE | waiting for operands, in_ready high
//   S_RUN  | shifting operands through the slice
//   S_DONE | result on y16, waiting for out_ready
module serial_logic16
  import iceberg_logic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a16,
  input  logic [WIDTH-1:0] b16,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y16,
  output logic             busy
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [1:0]       op_q, op_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [STEP-1:0]  slice_y;
  logic [WIDTH-1:0] res_shift;
  logic             unused_res_lsbs;

  logic_slice #(.STEP(STEP)) u_slice (
    .op (op_q),
    .a  (a_q[STEP-1:0]),
    .b  (b_q[STEP-1:0]),
    .y  (slice_y)
  );

  // New bits enter at the MSB so that after N steps bit i lines up with a[i]/b[i].
  generate
    if (STEP == WIDTH) begin : g_single
      assign res_shift       = slice_y;
      assign unused_res_lsbs = ^res_q;
    end else begin : g_multi
      assign res_shift       = {slice_y, res_q[WIDTH-1:STEP]};
      assign unused_res_lsbs = ^res_q[STEP-1:0];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    y_d         = y_q;
    op_d        = op_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d        = a16;
          b_d        = b16;
          op_d       = op;
          cnt_d      = '0;
          state_d    = S_RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_RUN: begin
        a_d   = a_q >> STEP;
        b_d   = b_q >> STEP;
        res_d = res_shift;
        if (cnt_q == CNT_LAST) begin
          state_d     = S_DONE;
          y_d         = res_shift;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      y_q         <= '0;
      op_q        <= OP_AND;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      y_q         <= y_d;
      op_q        <= op_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign y16       = y_q;

endmodule
